// File: rtl/dummy_dac.sv
// dummy_dac: drains the slot byte FIFO into 32-bit LE words, releases them on sample ticks and checks them against a pattern.
module dummy_dac #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          TICK_DIV   = 256,
  parameter logic [31:0] EXPECTED   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_read,
  input  logic [7:0]            fifo_data,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_in,
  input  logic [ADDR_WIDTH-1:0] fifo_addr_out,
  input  logic                  direction,
  input  logic                  channels,
  output logic [31:0]           sample_out,
  output logic                  sample_valid,
  output logic                  pattern_error,
  output logic [15:0]           error_count,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d, occ_q, occ_d, occ_p, need;
  logic [31:0] word_q, word_d, buf0_q, buf0_d, buf1_q, buf1_d, buf0_p, push_word;
  logic [31:0] sample_out_q, sample_out_d;
  logic [15:0] error_count_q, error_count_d, underrun_count_q, underrun_count_d;
  logic [CW-1:0] cnt_q;
  logic        pend_q, pend_d, sample_valid_q, pattern_error_q, pattern_error_d, underrun_q;
  logic        tick, fire, pop, push, go, mis, under;
  always_comb begin
    tick = cnt_q == CW'(TICK_DIV / 2 - 1);
    fire = tick && !direction;
    need = channels ? 2'd2 : 2'd1;
    // stereo pops the first word on the tick and the second via pend_q one cycle later
    pop = (fire && occ_q >= need) || pend_q;
    pend_d = fire && channels && occ_q >= 2'd2;
    under = fire && occ_q < need;
    push = state_q == CAPTURE && byte_idx_q == 2'd3;
    push_word = {fifo_data, word_q[23:0]};
    occ_p = occ_q - {1'b0, pop};
    buf0_p = pop ? buf1_q : buf0_q;
    buf0_d = (push && occ_p == 2'd0) ? push_word : buf0_p;
    buf1_d = (push && occ_p != 2'd0) ? push_word : buf1_q;
    occ_d = occ_p + {1'b0, push};
    go = !direction && fifo_addr_in != fifo_addr_out && occ_d < 2'd2;
    state_d = state_q == READ ? CAPTURE : go ? READ : IDLE;
    word_d = word_q;
    if (state_q == CAPTURE) word_d[8*byte_idx_q +: 8] = fifo_data;
    byte_idx_d = byte_idx_q + 2'(state_q == CAPTURE);
    sample_out_d = pop ? buf0_q : sample_out_q;
    mis = pop && buf0_q != EXPECTED;
    pattern_error_d = pattern_error_q || mis;
    error_count_d = error_count_q + 16'(mis && error_count_q != 16'hFFFF);
    underrun_count_d = underrun_count_q + 16'(under && underrun_count_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      byte_idx_q <= '0;
      occ_q <= '0;
      word_q <= '0;
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      sample_out_q <= '0;
      sample_valid_q <= 1'b0;
      pattern_error_q <= 1'b0;
      error_count_q <= '0;
      underrun_q <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      occ_q <= occ_d;
      word_q <= word_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q <= cnt_q + CW'(1);
      pend_q <= pend_d;
      sample_out_q <= sample_out_d;
      sample_valid_q <= pop;
      pattern_error_q <= pattern_error_d;
      error_count_q <= error_count_d;
      underrun_q <= under;
      underrun_count_q <= underrun_count_d;
    end
  end
  assign fifo_read = state_q == READ;
  assign sample_out = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign pattern_error = pattern_error_q;
  assign error_count = error_count_q;
  assign underrun = underrun_q;
  assign underrun_count = underrun_count_q;
endmodule

// File: tb/tb_dummy_dac.sv
// tb_dummy_dac: directed checks of dummy_dac against a byte-FIFO model with hand-computed timing.
module tb_dummy_dac;
  logic clk = 1'b0, reset = 1'b1, direction = 1'b0, channels = 1'b0;
  logic fifo_read, sample_valid, pattern_error, underrun;
  logic [7:0] fifo_data = '0;
  logic [10:0] wr_ptr = '0, rd_ptr = '0;
  logic [31:0] sample_out;
  logic [15:0] error_count, underrun_count;
  logic [7:0] mem [0:2047];
  int tests = 0, fails = 0, cyc = 0, n_rd, n_ur, n_sv;

  always #5 clk = ~clk;

  dummy_dac dut (
    .clk(clk), .reset(reset), .fifo_read(fifo_read), .fifo_data(fifo_data),
    .fifo_addr_in(wr_ptr), .fifo_addr_out(rd_ptr), .direction(direction), .channels(channels),
    .sample_out(sample_out), .sample_valid(sample_valid), .pattern_error(pattern_error),
    .error_count(error_count), .underrun(underrun), .underrun_count(underrun_count)
  );

  // slot FIFO: data valid the cycle after the read strobe, pointer advances on that edge
  always @(posedge clk)
    if (fifo_read) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 11'd1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic till(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 11'd1;
  endtask

  task automatic push32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push(w[8*i +: 8]);
  endtask

  task automatic rst_on();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_ptr = rd_ptr;
  endtask

  task automatic rst_off();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic count();
    n_rd += int'(fifo_read);
    n_ur += int'(underrun);
    n_sv += int'(sample_valid);
  endtask

  initial begin
    // reset in the middle of fetching
    rst_on();
    rst_off();
    push(8'h11);
    push(8'h22);
    till(3);
    chk("act_rd", fifo_read, 1);
    till(5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd", fifo_read, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_perr", pattern_error, 0);
    chk("rst_ecnt", error_count, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_ucnt", underrun_count, 0);
    wr_ptr = rd_ptr;
    reset = 1'b0;
    cyc = 0;
    nxt();
    chk("rst_rd_after1", fifo_read, 0);
    nxt();
    chk("rst_rd_after2", fifo_read, 0);

    // mono nominal
    channels = 1'b0;
    rst_on();
    push32(32'hDEADBEEF);
    rst_off();
    for (int k = 0; k < 10; k++) begin
      chk("mono_rd", fifo_read, 32'((k % 2 == 1) && (k < 8)));
      nxt();
    end
    till(127);
    chk("mono_sv_pre", sample_valid, 0);
    nxt();
    chk("mono_sv", sample_valid, 1);
    chk("mono_out", sample_out, 32'hDEADBEEF);
    chk("mono_ecnt", error_count, 0);
    chk("mono_ucnt", underrun_count, 0);
    chk("mono_perr", pattern_error, 0);
    nxt();
    chk("mono_sv_post", sample_valid, 0);
    chk("mono_hold", sample_out, 32'hDEADBEEF);

    // stereo with a mismatching second word
    channels = 1'b1;
    rst_on();
    push32(32'hDEADBEEF);
    push32(32'h04030201);
    rst_off();
    till(128);
    chk("st_sv1", sample_valid, 1);
    chk("st_out1", sample_out, 32'hDEADBEEF);
    chk("st_perr1", pattern_error, 0);
    chk("st_ecnt1", error_count, 0);
    nxt();
    chk("st_sv2", sample_valid, 1);
    chk("st_out2", sample_out, 32'h04030201);
    chk("st_perr2", pattern_error, 1);
    chk("st_ecnt2", error_count, 1);
    nxt();
    chk("st_sv3", sample_valid, 0);
    chk("st_perr3", pattern_error, 1);
    chk("st_ucnt", underrun_count, 0);

    // underruns on an empty FIFO
    channels = 1'b0;
    rst_on();
    rst_off();
    n_rd = 0; n_ur = 0; n_sv = 0;
    while (cyc < 646) begin
      count();
      if (cyc == 128) chk("ur_at_128", underrun, 1);
      nxt();
    end
    chk("ur_pulses", n_ur, 3);
    chk("ur_sv", n_sv, 0);
    chk("ur_rd", n_rd, 0);
    chk("ur_cnt", underrun_count, 3);

    // direction gating across a partial word
    rst_on();
    push(8'hEF);
    push(8'hBE);
    rst_off();
    till(10);
    direction = 1'b1;
    till(20);
    push(8'hAD);
    push(8'hDE);
    n_rd = 0; n_ur = 0; n_sv = 0;
    while (cyc < 400) begin count(); nxt(); end
    chk("dir_rd_off", n_rd, 0);
    chk("dir_ur_off", n_ur, 0);
    chk("dir_sv_off", n_sv, 0);
    direction = 1'b0;
    n_rd = 0; n_ur = 0; n_sv = 0;
    while (cyc < 646) begin
      count();
      if (cyc == 640) begin
        chk("dir_sv", sample_valid, 1);
        chk("dir_out", sample_out, 32'hDEADBEEF);
      end
      nxt();
    end
    chk("dir_nsv", n_sv, 1);
    chk("dir_nrd", n_rd, 2);
    chk("dir_ucnt", underrun_count, 0);
    chk("dir_ecnt", error_count, 0);

    // buffer full back-pressure, then counter saturation
    rst_on();
    repeat (3) push32(32'hDEADBEEF);
    rst_off();
    n_rd = 0;
    while (cyc < 128) begin n_rd += int'(fifo_read); nxt(); end
    chk("full_rd_pre", n_rd, 8);
    chk("full_rd_resume", fifo_read, 1);
    chk("full_sv", sample_valid, 1);
    while (cyc < 141) begin n_rd += int'(fifo_read); nxt(); end
    chk("full_rd_total", n_rd, 12);
    till(700);
    force dut.underrun_count_q = 16'hFFFE;
    nxt();
    release dut.underrun_count_q;
    nxt();
    chk("sat_preset", underrun_count, 16'hFFFE);
    till(896);
    chk("sat_ur1", underrun, 1);
    nxt();
    chk("sat_cnt1", underrun_count, 16'hFFFF);
    till(1152);
    chk("sat_ur2", underrun, 1);
    nxt();
    chk("sat_cnt2", underrun_count, 16'hFFFF);
    chk("sat_ecnt", error_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dummy_dac.md
# dummy_dac

Stand-in playback converter that drains the slot's byte FIFO, which the host fills through the FX2 port. It is the consumer-side counterpart of the dummy ADC. It reads bytes from the slot FIFO, assembles them into 32-bit little-endian words, and releases one word (mono) or two words (stereo) per sample tick. Each released word is checked against a fixed pattern, and underruns and mismatches are counted so that the host-to-FIFO path can be validated end to end without real DAC hardware.

## Interface
Parameters:
- `ADDR_WIDTH`, default 11: width of the FIFO pointers.
- `TICK_DIV`, default 256: sample tick period in `clk` cycles (100 MHz / 256 ≈ 390 kHz). Must be a power of two, at least 16.
- `EXPECTED`, default 32'hDEADBEEF: pattern each released word is compared against.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; clears all state.
- `fifo_read`  out  1  registered read strobe to the slot FIFO.
- `fifo_data`  in  8  FIFO read data; valid the cycle after `fifo_read`.
- `fifo_addr_in`  in  ADDR_WIDTH  FIFO write pointer (producer side).
- `fifo_addr_out`  in  ADDR_WIDTH  FIFO read pointer; the FIFO advances it on the edge that samples `fifo_read`=1.
- `direction`  in  1  slot direction; 0 = playback/DAC (block active), 1 = capture (block idle).
- `channels`  in  1  0 = mono (1 word per tick), 1 = stereo (2 words per tick).
- `sample_out`  out  32  last released word.
- `sample_valid`  out  1  one-cycle strobe per released word.
- `pattern_error`  out  1  sticky; set on any mismatch against `EXPECTED`.
- `error_count`  out  16  count of mismatching words; saturates at 16'hFFFF.
- `underrun`  out  1  one-cycle strobe on a tick with too few buffered words.
- `underrun_count`  out  16  count of underruns; saturates at 16'hFFFF.

## Operation
- FIFO empty is defined as `fifo_addr_in == fifo_addr_out`. Pointer wrap is handled by the FIFO; this block only compares the two pointers for equality.
- Fetch FSM, with states IDLE, READ and CAPTURE:
  - IDLE → READ when `direction`=0, the FIFO is not empty, and the word buffer holds fewer than 2 words (counting a word completing this cycle).
  - READ: `fifo_read`=1 for exactly one cycle, then → CAPTURE.
  - CAPTURE: latch `fifo_data` into byte lane `byte_idx` (first byte → [7:0], fourth byte → [31:24]), then increment `byte_idx` (mod 4).
  - On `byte_idx`=3, the assembled word is pushed into the word buffer.
  - CAPTURE → READ directly if the IDLE→READ conditions still hold; otherwise → IDLE.
- Reads are never issued on back-to-back cycles. The minimum cost is 2 cycles per byte and 8 cycles per word.
- Word buffer: 2-entry FIFO. A simultaneous push and pop leaves occupancy unchanged, and the order is preserved.
- Tick generator: a free-running counter modulo `TICK_DIV`. `tick` is asserted when the count equals `TICK_DIV/2 - 1`, i.e. 127 at the default.
- Drain, on `tick` with `direction`=0:
  - Required words are 1 (mono) or 2 (stereo), with `channels` sampled at the tick.
  - If occupancy ≥ required: pop the words. Mono releases one word the cycle after `tick`. Stereo releases the second word on the following cycle.
  - If occupancy < required: pulse `underrun`, increment `underrun_count`, and pop nothing.
- Ticks with `direction`=1 are ignored: no underrun is counted and nothing is released.
- Pattern check: each released word is compared against `EXPECTED`. A mismatch sets `pattern_error` and increments `error_count`, both in the same cycle as `sample_valid`.
- When `direction` goes to 1 mid-word:
  - An in-flight READ/CAPTURE pair completes.
  - The FSM then parks in IDLE, keeping the partial word and `byte_idx`.
  - Fetching resumes when `direction` returns to 0.
- Reset at any point clears the FSM, the buffer, `byte_idx`, the counters and all outputs. An in-flight read byte is discarded.

## Timing
- Reset values: `fifo_read`=0, `sample_out`=0, `sample_valid`=0, `pattern_error`=0, `error_count`=0, `underrun`=0, `underrun_count`=0, tick counter=0.
- After reset deassertion, the first `tick` falls on counter value `TICK_DIV/2 - 1`. Later ticks follow every `TICK_DIV` cycles.
- Read handshake:
  - Cycle N: `fifo_read`=1.
  - Cycle N+1: `fifo_data` valid and the pointer has advanced; the block samples `fifo_data` at the end of N+1.
  - Cycle N+2: earliest next `fifo_read`.
- Release latency: `sample_valid` is asserted 1 cycle after `tick` (mono), or 1 and 2 cycles after `tick` (stereo). `sample_out` holds its value between strobes.
- Fetch latency: a word pushed on a tick cycle is not counted for that tick. Only occupancy registered before the tick edge counts.
- Counters saturate and never wrap. `pattern_error` clears only on reset.

## Test plan
- Reset: hold `reset` for 3 cycles during activity → all outputs 0, and `fifo_read` stays 0 the cycle after release with an empty FIFO.
- Mono nominal: FIFO model preloaded with EF BE AD DE, `direction`=0, `channels`=0 → exactly 4 `fifo_read` pulses spaced 2 cycles apart. Then `sample_out`=32'hDEADBEEF with `sample_valid` at cycle 128 after reset; `error_count`=0, `underrun_count`=0.
- Stereo mismatch: preload EF BE AD DE 01 02 03 04, `channels`=1 → consecutive strobes with 32'hDEADBEEF then 32'h04030201. `pattern_error`=1 and `error_count`=1 on the second strobe.
- Underrun: empty FIFO for 3 ticks → 3 `underrun` pulses, `underrun_count`=3, no `sample_valid`, no `fifo_read`.
- Direction gating: switch `direction` to 1 after 2 bytes, run 2 ticks, then return to 0 and supply 2 more bytes → no underruns while `direction`=1, and the next release is 32'hDEADBEEF assembled across the gap.
- Buffer full and saturation: keep the FIFO non-empty with `channels`=0 → `fifo_read` stops once 2 words are buffered and resumes after each pop. Force `underrun_count` to 16'hFFFE, then cause 2 underruns → `underrun_count` holds at 16'hFFFF.
